// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing control for the 5-stage pipeline.
// Resolves load-use stalls and taken-branch squashes, freezes the pipe while a
// data-memory access is outstanding (with timeout to a sticky error state),
// and keeps saturating stall/flush counters for performance monitoring.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             branch_taken,
    input  logic             ex_mem_MemRead,
    input  logic             ex_mem_MemWrite,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pipe_freeze,
    output logic             mem_error,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        ERROR    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    flush_q, flush_d;

    logic acc;
    logic lu;
    logic frz;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign acc = ex_mem_MemRead | ex_mem_MemWrite;
    assign lu  = id_ex_MemRead & (id_ex_rd != 5'd0) &
                 ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
    assign frz = (state_q == ERROR) | (acc & ~mem_ready);

    // Pipeline controls: reset, then freeze, then branch squash, then load-use bubble.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (frz) begin
            // Held hazards are re-evaluated once the freeze releases.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_freeze  = 1'b1;
        end else if (branch_taken) begin
            // Wrong-path load-use is discarded along with the squashed instructions.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // Memory-wait FSM next state and timeout counter.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            RUN: begin
                if (acc && !mem_ready) begin
                    state_d = WAIT_MEM;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            WAIT_MEM: begin
                if (mem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(TIMEOUT)) begin
                    state_d = ERROR;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Performance counter next values.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (frz || (lu && !branch_taken)) stall_d = sat_inc(stall_q);
        if (branch_taken && !frz)         flush_d = sat_inc(flush_q);
    end

    // State, wait counter and performance counters; async active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign mem_error = (state_q == ERROR);
    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl built with CNT_W=4 and TIMEOUT=4.
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_ex_MemRead;
    logic [4:0]       id_ex_rd;
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             branch_taken;
    logic             ex_mem_MemRead;
    logic             ex_mem_MemWrite;
    logic             mem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             pipe_freeze;
    logic             mem_error;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze}
    logic [5:0] ctl;
    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze};

    localparam logic [5:0] CTL_RESET  = 6'b001110;
    localparam logic [5:0] CTL_FREEZE = 6'b000001;
    localparam logic [5:0] CTL_BRANCH = 6'b111110;
    localparam logic [5:0] CTL_LU     = 6'b000100;
    localparam logic [5:0] CTL_RUN    = 6'b110000;

    int tests = 0;
    int fails = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .branch_taken(branch_taken),
        .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
        .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .pipe_freeze(pipe_freeze), .mem_error(mem_error), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        id_ex_MemRead   = 1'b0;
        id_ex_rd        = 5'd0;
        if_id_rs1       = 5'd0;
        if_id_rs2       = 5'd0;
        branch_taken    = 1'b0;
        ex_mem_MemRead  = 1'b0;
        ex_mem_MemWrite = 1'b0;
        mem_ready       = 1'b0;
    endtask

    task automatic set_lu(input logic on);
        id_ex_MemRead = on;
        id_ex_rd      = on ? 5'd5 : 5'd0;
        if_id_rs1     = 5'd3;
        if_id_rs2     = on ? 5'd5 : 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #3;
        tests++; if (ctl !== CTL_RESET) begin fails++; $display("FAIL reset_ctl got %b exp %b", ctl, CTL_RESET); end
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state); end
        tests++; if (mem_error !== 1'b0) begin fails++; $display("FAIL reset_mem_error got %b exp 0", mem_error); end
        tests++; if ({stall_cnt, flush_cnt} !== '0) begin fails++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL idle_ctl got %b exp %b", ctl, CTL_RUN); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu(1'b1);
        #1;
        tests++; if (ctl !== CTL_LU) begin fails++; $display("FAIL lu_ctl got %b exp %b", ctl, CTL_LU); end
        @(negedge clk);
        tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
        // Same load but destination x0: never a hazard.
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
        #1;
        tests++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL lu_x0_ctl got %b exp %b", ctl, CTL_RUN); end
        // Match on rs1 instead of rs2.
        @(negedge clk);
        tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_x0_stall_cnt got %0d exp 1", stall_cnt); end
        id_ex_rd = 5'd9; if_id_rs1 = 5'd9; if_id_rs2 = 5'd2;
        #1;
        tests++; if (ctl !== CTL_LU) begin fails++; $display("FAIL lu_rs1_ctl got %b exp %b", ctl, CTL_LU); end
        @(negedge clk);
        idle_inputs();
        tests++; if (stall_cnt !== 4'd2) begin fails++; $display("FAIL lu_rs1_stall_cnt got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        set_lu(1'b1);
        branch_taken = 1'b1;
        #1;
        tests++; if (ctl !== CTL_BRANCH) begin fails++; $display("FAIL br_ctl got %b exp %b", ctl, CTL_BRANCH); end
        @(negedge clk);
        idle_inputs();
        tests++; if (flush_cnt !== 4'd1) begin fails++; $display("FAIL br_flush_cnt got %0d exp 1", flush_cnt); end
        tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL br_stall_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_mem_wait();
        logic [1:0] exp_st;
        do_reset();
        // Access ready in its first cycle: no freeze, no state change.
        ex_mem_MemRead = 1'b1; mem_ready = 1'b1;
        #1;
        tests++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL mem_fast_ctl got %b exp %b", ctl, CTL_RUN); end
        @(negedge clk);
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL mem_fast_state got %0d exp 0", state); end
        // Three not-ready cycles with a branch and load-use held behind the freeze.
        mem_ready = 1'b0; branch_taken = 1'b1; set_lu(1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_st = (i == 0) ? 2'd0 : 2'd1;
            #1;
            tests++; if (ctl !== CTL_FREEZE) begin fails++; $display("FAIL mem_frz_ctl[%0d] got %b exp %b", i, ctl, CTL_FREEZE); end
            tests++; if (state !== exp_st) begin fails++; $display("FAIL mem_frz_state[%0d] got %0d exp %0d", i, state, exp_st); end
            @(negedge clk);
        end
        mem_ready = 1'b1; branch_taken = 1'b0; set_lu(1'b0);
        #1;
        tests++; if (ctl !== CTL_RUN) begin fails++; $display("FAIL mem_release_ctl got %b exp %b", ctl, CTL_RUN); end
        @(negedge clk);
        idle_inputs();
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL mem_release_state got %0d exp 0", state); end
        tests++; if (stall_cnt !== 4'd3) begin fails++; $display("FAIL mem_stall_cnt got %0d exp 3", stall_cnt); end
        tests++; if (flush_cnt !== 4'd0) begin fails++; $display("FAIL mem_flush_cnt got %0d exp 0", flush_cnt); end
    endtask

    task automatic test_timeout();
        logic [1:0] exp_st;
        do_reset();
        ex_mem_MemWrite = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            @(negedge clk);
            exp_st = (i == TIMEOUT + 1) ? 2'd2 : 2'd1;
            tests++; if (state !== exp_st) begin fails++; $display("FAIL to_state[%0d] got %0d exp %0d", i, state, exp_st); end
        end
        tests++; if (mem_error !== 1'b1) begin fails++; $display("FAIL to_mem_error got %b exp 1", mem_error); end
        // Memory finally answers and the access disappears: error stays sticky.
        ex_mem_MemWrite = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        tests++; if ({ctl, mem_error, state} !== {CTL_FREEZE, 1'b1, 2'd2}) begin fails++; $display("FAIL to_sticky got %b/%b/%0d exp %b/1/2", ctl, mem_error, state, CTL_FREEZE); end
        // Async reset between edges clears immediately.
        #2;
        reset = 1'b0;
        #1;
        tests++; if ({state, mem_error, ctl} !== {2'd0, 1'b0, CTL_RESET}) begin fails++; $display("FAIL to_reset got %0d/%b/%b exp 0/0/%b", state, mem_error, ctl, CTL_RESET); end
        tests++; if ({stall_cnt, flush_cnt} !== '0) begin fails++; $display("FAIL to_reset_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
    endtask

    task automatic test_async_reset_mid_freeze();
        do_reset();
        ex_mem_MemRead = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if ({state, pipe_freeze, stall_cnt} !== {2'd1, 1'b1, 4'd2}) begin fails++; $display("FAIL arst_pre got %0d/%b/%0d exp 1/1/2", state, pipe_freeze, stall_cnt); end
        #1;
        reset = 1'b0;
        #1;
        tests++; if ({state, ctl, stall_cnt} !== {2'd0, CTL_RESET, 4'd0}) begin fails++; $display("FAIL arst_mid got %0d/%b/%0d exp 0/%b/0", state, ctl, stall_cnt, CTL_RESET); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        set_lu(1'b1);
        repeat (20) @(negedge clk);
        tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_stall_cnt got %0d exp 15", stall_cnt); end
        set_lu(1'b0);
        branch_taken = 1'b1;
        repeat (20) @(negedge clk);
        tests++; if ({stall_cnt, flush_cnt} !== {4'd15, 4'd15}) begin fails++; $display("FAIL sat_cnts got %0d/%0d exp 15/15", stall_cnt, flush_cnt); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset_mid_freeze();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
